bcd_adder_2digit: RTL and testbench

- Registered two-digit (8-bit) packed-BCD adder with carry-in and carry-out.
- Adds two BCD operands plus a 1-bit carry using ripple decimal-digit correction (digit sum > 9 -> add 6, carry to next digit).
- Result, carry and status are captured in output registers with one-cycle latency.
- Sits in datapath arithmetic wherever decimal (display/counter) values are accumulated.

---
 rtl/bcd_adder_2digit.sv | 78 +++++++
 tb/tb_bcd_adder_2digit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_adder_2digit.sv
// Registered packed-BCD adder with decimal carry ripple across digits.
// Invalid (non-decimal) operand digits force a zero result and raise err.
module bcd_adder_2digit #(
    parameter int unsigned NDIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*NDIGITS-1:0]   A,
    input  logic [4*NDIGITS-1:0]   B,
    input  logic                   Cin,
    input  logic                   in_valid,
    output logic [4*NDIGITS-1:0]   S,
    output logic                   Cout,
    output logic                   out_valid,
    output logic                   err
);

    localparam int unsigned W = 4 * NDIGITS;

    logic [W-1:0]     w_sum;
    logic [NDIGITS:0] w_c;
    logic [4:0]       w_t [NDIGITS];
    logic             w_bad;

    logic [W-1:0]     r_s;
    logic             r_cout;
    logic             r_valid;
    logic             r_err;

    always_comb begin
        w_sum  = '0;
        w_c    = '0;
        w_c[0] = Cin;
        w_bad  = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            w_t[i] = {1'b0, A[4*i +: 4]} + {1'b0, B[4*i +: 4]} + {4'b0000, w_c[i]};
            if (w_t[i] > 5'd9) begin
                w_sum[4*i +: 4] = w_t[i][3:0] + 4'd6;
                w_c[i+1]        = 1'b1;
            end else begin
                w_sum[4*i +: 4] = w_t[i][3:0];
                w_c[i+1]        = 1'b0;
            end
            if ((A[4*i +: 4] > 4'd9) || (B[4*i +: 4] > 4'd9)) begin
                w_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (in_valid) begin
            r_valid <= 1'b1;
            // A bad digit overrides the arithmetic result entirely.
            if (w_bad) begin
                r_s    <= '0;
                r_cout <= 1'b0;
                r_err  <= 1'b1;
            end else begin
                r_s    <= w_sum;
                r_cout <= w_c[NDIGITS];
                r_err  <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign S         = r_s;
    assign Cout      = r_cout;
    assign out_valid = r_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_bcd_adder_2digit.sv
// Self-checking bench for bcd_adder_2digit: directed cases, exhaustive valid
// operands and random (possibly invalid) operands against a decimal model.
module tb_bcd_adder_2digit;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       in_valid;
    logic [7:0] S;
    logic       Cout;
    logic       out_valid;
    logic       err;

    int n_checks;
    int n_fail;

    bcd_adder_2digit #(.NDIGITS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand set and sample the registered result 1 time unit after the edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
        A        = a;
        B        = b;
        Cin      = c;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic int dec_of(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] bcd_of(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                  output logic [7:0] s, output logic co, output logic e);
        int sum;
        e = (a[7:4] > 9) || (a[3:0] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
        if (e) begin
            s  = 8'h00;
            co = 1'b0;
        end else begin
            sum = dec_of(a) + dec_of(b) + int'(c);
            s   = bcd_of(sum % 100);
            co  = (sum >= 100);
        end
    endfunction

    task automatic check_model(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic c);
        logic [7:0] es;
        logic       ec;
        logic       ee;
        model(a, b, c, es, ec, ee);
        chk({tag, "_s"}, S, es);
        chk({tag, "_cout"}, {7'd0, Cout}, {7'd0, ec});
        chk({tag, "_err"}, {7'd0, err}, {7'd0, ee});
        chk({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        n_checks = 0;
        n_fail   = 0;

        // Reset held with live inputs: outputs stay cleared across clock edges.
        rst_n    = 1'b0;
        A        = 8'h55;
        B        = 8'h55;
        Cin      = 1'b0;
        in_valid = 1'b1;
        #3;
        chk("rst_s", S, 8'h00);
        chk("rst_cout", {7'd0, Cout}, 8'd0);
        chk("rst_ov", {7'd0, out_valid}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_s", S, 8'h00);
        chk("rst_hold_ov", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_s", S, 8'h10);
        chk("rel_cout", {7'd0, Cout}, 8'd1);
        chk("rel_ov", {7'd0, out_valid}, 8'd1);
        chk("rel_err", {7'd0, err}, 8'd0);

        // Back-to-back basic adds.
        step(8'h12, 8'h05, 1'b0, 1'b1);
        chk("add1_s", S, 8'h17);
        chk("add1_cout", {7'd0, Cout}, 8'd0);

        // Hold: idle cycles keep S, drop out_valid.
        for (int i = 0; i < 3; i++) begin
            step(8'h33, 8'h33, 1'b1, 1'b0);
            chk("hold_s", S, 8'h17);
            chk("hold_ov", {7'd0, out_valid}, 8'd0);
        end

        step(8'h29, 8'h19, 1'b1, 1'b1);
        chk("add2_s", S, 8'h49);
        chk("add2_cout", {7'd0, Cout}, 8'd0);
        chk("add2_ov", {7'd0, out_valid}, 8'd1);

        step(8'h45, 8'h55, 1'b0, 1'b1);
        chk("ovf1_s", S, 8'h00);
        chk("ovf1_cout", {7'd0, Cout}, 8'd1);
        step(8'h99, 8'h01, 1'b0, 1'b1);
        chk("ovf2_s", S, 8'h00);
        chk("ovf2_cout", {7'd0, Cout}, 8'd1);
        step(8'h99, 8'h99, 1'b1, 1'b1);
        chk("max_s", S, 8'h99);
        chk("max_cout", {7'd0, Cout}, 8'd1);

        // Invalid digit with Cin set, then recovery.
        step(8'h1A, 8'h01, 1'b1, 1'b1);
        chk("bad_err", {7'd0, err}, 8'd1);
        chk("bad_s", S, 8'h00);
        chk("bad_cout", {7'd0, Cout}, 8'd0);
        chk("bad_ov", {7'd0, out_valid}, 8'd1);
        step(8'h08, 8'h02, 1'b0, 1'b1);
        chk("rec_err", {7'd0, err}, 8'd0);
        chk("rec_s", S, 8'h10);
        chk("rec_cout", {7'd0, Cout}, 8'd0);

        // Asynchronous reset between edges clears outputs without a clock.
        step(8'h29, 8'h19, 1'b1, 1'b1);
        chk("pre_arst_s", S, 8'h49);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_s", S, 8'h00);
        chk("arst_ov", {7'd0, out_valid}, 8'd0);
        chk("arst_err", {7'd0, err}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_arst_ov", {7'd0, out_valid}, 8'd0);
        chk("post_arst_s", S, 8'h00);

        // Exhaustive valid operands.
        for (int a = 0; a < 100; a++) begin
            for (int b = 0; b < 100; b++) begin
                for (int c = 0; c < 2; c++) begin
                    step(bcd_of(a), bcd_of(b), c[0], 1'b1);
                    check_model("exh", bcd_of(a), bcd_of(b), c[0]);
                end
            end
        end

        // Random raw bytes, including non-decimal digits.
        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            step(ra, rb, rc, 1'b1);
            check_model("rnd", ra, rb, rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
